// File: rtl/nonce_tx_scheduler.sv
// nonce_tx_scheduler: arbitrates found nonces from SLAVES hashing cores onto
// the single serial_core transmit path. One-deep slot per slave, round-robin
// grant, one word per serial_core frame, with a busy-rise timeout.

// One slave's nonce slot: holds the latest accepted nonce until it is granted.
module nonce_slot #(
  parameter int NONCE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_nonce,
  input  logic [NONCE_WIDTH-1:0] nonce_in,
  input  logic                   grant,
  output logic [NONCE_WIDTH-1:0] hold,
  output logic                   pending,
  output logic                   drop
);
  // A nonce arriving on an occupied slot that is not draining this cycle is lost
  assign drop = new_nonce & pending & ~grant;

  // Accept into an empty slot, or refill a slot whose old word leaves this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold    <= '0;
      pending <= 1'b0;
    end else begin
      if (new_nonce && (!pending || grant)) hold <= nonce_in;
      if (grant)          pending <= new_nonce;
      else if (new_nonce) pending <= 1'b1;
    end
  end
endmodule

module nonce_tx_scheduler #(
  parameter int SLAVES       = 4,
  parameter int NONCE_WIDTH  = 32,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SLAVES-1:0]             new_nonces,
  input  logic [SLAVES*NONCE_WIDTH-1:0] slave_nonces,
  input  logic                          serial_busy,
  output logic [NONCE_WIDTH-1:0]        golden_nonce,
  output logic                          serial_send,
  output logic [SLAVES-1:0]             pending,
  output logic [7:0]                    overflow_count,
  output logic                          tx_active
);
  localparam int LGW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int TW  = $clog2(BUSY_TIMEOUT + 1);
  localparam int CW  = $clog2(SLAVES + 2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                               state, state_nxt;
  logic [TW-1:0]                        timer;
  logic [LGW-1:0]                       last_grant, grant_idx;
  logic                                 grant_found, grant_en;
  logic                                 timeout_hit, timeout_lost;
  logic [SLAVES-1:0]                    grant_vec, drop_vec;
  logic [SLAVES-1:0][NONCE_WIDTH-1:0]   hold;
  logic [CW-1:0]                        drop_sum;
  logic [8:0]                           ovf_sum;

  for (genvar i = 0; i < SLAVES; i++) begin : g_slot
    assign grant_vec[i] = grant_en && (grant_idx == LGW'(i));
    nonce_slot #(.NONCE_WIDTH(NONCE_WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .new_nonce (new_nonces[i]),
      .nonce_in  (slave_nonces[i*NONCE_WIDTH +: NONCE_WIDTH]),
      .grant     (grant_vec[i]),
      .hold      (hold[i]),
      .pending   (pending[i]),
      .drop      (drop_vec[i])
    );
  end

  // Round-robin pick: first pending slot after last_grant, wrapping to 0
  always_comb begin
    int             idx;
    logic [LGW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = last_grant;
    for (int k = 1; k <= SLAVES; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= SLAVES) idx = idx - SLAVES;
      cand = LGW'(idx);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // State register; timer counts cycles elapsed since SEND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      last_grant <= LGW'(SLAVES - 1);
    end else begin
      state <= state_nxt;
      if (grant_en) last_grant <= grant_idx;
      case (state)
        SEND:      timer <= TW'(1);
        WAIT_BUSY: timer <= timer + TW'(1);
        default:   timer <= '0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant_en) state_nxt = SEND;
      SEND:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (serial_busy) state_nxt = WAIT_DONE;
                 else if (timeout_hit) state_nxt = IDLE;
      WAIT_DONE: if (!serial_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Decoded controls: grant qualification, lost-frame detect, drop tally
  always_comb begin
    grant_en     = (state == IDLE) && grant_found && !serial_busy;
    timeout_hit  = (timer == TW'(BUSY_TIMEOUT - 1));
    timeout_lost = (state == WAIT_BUSY) && !serial_busy && timeout_hit;
    drop_sum     = CW'(timeout_lost);
    for (int i = 0; i < SLAVES; i++) drop_sum = drop_sum + CW'(drop_vec[i]);
    ovf_sum      = {1'b0, overflow_count} + 9'(drop_sum);
  end

  // Registered outputs; golden_nonce only moves on a grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      golden_nonce   <= '0;
      serial_send    <= 1'b0;
      tx_active      <= 1'b0;
      overflow_count <= '0;
    end else begin
      serial_send    <= (state_nxt == SEND);
      tx_active      <= (state_nxt != IDLE);
      overflow_count <= (ovf_sum > 9'd255) ? 8'hFF : ovf_sum[7:0];
      if (grant_en) golden_nonce <= hold[grant_idx];
    end
  end
endmodule

// File: tb/tb_nonce_tx_scheduler.sv
// Bench for nonce_tx_scheduler: directed table and sequences with hand-derived
// expectations, plus randomized traffic checked every cycle against a
// transaction-level reference model.
module tb_nonce_tx_scheduler;
  localparam int S  = 4;
  localparam int NW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [S-1:0]    new_nonces;
  logic [S*NW-1:0] slave_nonces;
  logic            serial_busy, man_busy, core_busy, auto_core;
  logic [NW-1:0]   golden_nonce;
  logic            serial_send;
  logic [S-1:0]    pending;
  logic [7:0]      overflow_count;
  logic            tx_active;

  assign serial_busy = auto_core ? core_busy : man_busy;
  always #5 clk = ~clk;

  nonce_tx_scheduler #(.SLAVES(S), .NONCE_WIDTH(NW), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .new_nonces(new_nonces), .slave_nonces(slave_nonces),
    .serial_busy(serial_busy), .golden_nonce(golden_nonce), .serial_send(serial_send),
    .pending(pending), .overflow_count(overflow_count), .tx_active(tx_active)
  );

  int checks = 0, errors = 0;

  // Reference model: slots, round-robin pointer, transmit phase
  // (0 idle, 1 send strobe, 2 awaiting busy, 3 frame in flight)
  logic [NW-1:0] m_hold [S];
  logic [S-1:0]  m_pend;
  logic [NW-1:0] m_gold;
  int            m_last, m_mode, m_ovf, m_sendcyc, cyc;

  // serial_core stand-in and log of words handed to it
  int            rsp_wait, rsp_hold, rise_lo, rise_hi, hold_lo, hold_hi;
  logic [NW-1:0] sent_q [$];

  function automatic logic [S*NW-1:0] pack(input logic [NW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_hold[i] = '0;
    m_pend = '0; m_gold = '0; m_last = S - 1; m_mode = 0; m_ovf = 0; m_sendcyc = 0;
  endtask

  task automatic model_edge();
    int g, drops;
    logic [S-1:0] old_pend;
    cyc++;
    if (rst) begin model_reset(); return; end
    g = -1; drops = 0; old_pend = m_pend;
    if (m_mode == 0 && m_pend != '0 && !serial_busy)
      for (int k = 1; k <= S; k++)
        if (g < 0 && m_pend[(m_last + k) % S]) g = (m_last + k) % S;
    if (g >= 0) begin m_gold = m_hold[g]; m_pend[g] = 1'b0; m_last = g; end
    for (int i = 0; i < S; i++)
      if (new_nonces[i]) begin
        if (old_pend[i] && i != g) drops++;
        else begin m_hold[i] = slave_nonces[i*NW +: NW]; m_pend[i] = 1'b1; end
      end
    case (m_mode)
      0: if (g >= 0) begin m_mode = 1; m_sendcyc = cyc; end
      1: m_mode = 2;
      2: if (serial_busy) m_mode = 3;
         else if (cyc - m_sendcyc == TO) begin m_mode = 0; drops++; end
      default: if (!serial_busy) m_mode = 0;
    endcase
    m_ovf = (m_ovf + drops > 255) ? 255 : m_ovf + drops;
  endtask

  task automatic model_cmp();
    checks++;
    if (serial_send !== (m_mode == 1) || tx_active !== (m_mode != 0) || pending !== m_pend ||
        golden_nonce !== m_gold || overflow_count !== 8'(m_ovf)) begin
      errors++;
      $display("FAIL model cyc %0d: send %b/%b act %b/%b pend %b/%b gold %h/%h ovf %0d/%0d",
               cyc, serial_send, m_mode == 1, tx_active, m_mode != 0, pending, m_pend,
               golden_nonce, m_gold, overflow_count, m_ovf);
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_cmp();
    if (serial_send === 1'b1) sent_q.push_back(golden_nonce);
    if (rsp_wait > 0) begin
      rsp_wait--;
      if (rsp_wait == 0) begin core_busy = 1'b1; rsp_hold = $urandom_range(hold_hi, hold_lo); end
    end else if (core_busy) begin
      rsp_hold--;
      if (rsp_hold <= 0) core_busy = 1'b0;
    end
    if (serial_send === 1'b1 && auto_core) rsp_wait = $urandom_range(rise_hi, rise_lo);
  endtask

  task automatic do_reset();
    rst = 1'b1; new_nonces = '0; slave_nonces = '0; man_busy = 1'b0;
    auto_core = 1'b0; core_busy = 1'b0; rsp_wait = 0;
    model_reset();
    #1;
    chk("rst golden", golden_nonce, 0);
    chk("rst send", serial_send, 0);
    chk("rst pending", pending, 0);
    chk("rst ovf", overflow_count, 0);
    chk("rst active", tx_active, 0);
    step();
    rst = 1'b0;
    sent_q.delete();
  endtask

  task automatic wait_send(input string name, input int limit);
    int n = 0;
    while (n < limit && serial_send !== 1'b1) begin step(); n++; end
    checks++;
    if (serial_send !== 1'b1) begin errors++; $display("FAIL %s: no serial_send in %0d cycles", name, limit); end
  endtask

  task automatic wait_sent(input string name, input int cnt, input int limit);
    int n = 0;
    while (n < limit && sent_q.size() < cnt) begin step(); n++; end
    chk(name, sent_q.size(), cnt);
  endtask

  task automatic wait_quiet(input string name, input int limit);
    int n = 0;
    while (n < limit && (tx_active !== 1'b0 || pending !== '0)) begin step(); n++; end
    checks++;
    if (tx_active !== 1'b0 || pending !== '0) begin errors++; $display("FAIL %s: not idle after %0d cycles", name, limit); end
  endtask

  typedef struct {
    logic [S-1:0]  nn;
    logic [NW-1:0] n0;
    logic          busy;
    int            reps;
    logic          e_send;
    logic [S-1:0]  e_pend;
    logic          e_act;
    logic [NW-1:0] e_gold;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int   nsend;
    logic [S*NW-1:0] rv;
    logic [S-1:0]    rn;

    // Single-nonce transaction: inputs for a cycle, outputs after its edge
    tbl[0] = '{4'b0001, 32'hDEADBEEF, 1'b0, 1,  1'b0, 4'b0001, 1'b0, 32'h0};
    tbl[1] = '{4'b0000, 32'h0,        1'b0, 1,  1'b1, 4'b0000, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{4'b0000, 32'h0,        1'b0, 2,  1'b0, 4'b0000, 1'b1, 32'hDEADBEEF};
    tbl[3] = '{4'b0000, 32'h0,        1'b1, 36, 1'b0, 4'b0000, 1'b1, 32'hDEADBEEF};
    tbl[4] = '{4'b0000, 32'h0,        1'b0, 2,  1'b0, 4'b0000, 1'b0, 32'hDEADBEEF};

    cyc = 0; rise_lo = 2; rise_hi = 2; hold_lo = 5; hold_hi = 5;
    do_reset();

    for (int r = 0; r < 5; r++)
      for (int k = 0; k < tbl[r].reps; k++) begin
        new_nonces = tbl[r].nn; slave_nonces = pack(tbl[r].n0, 0, 0, 0); man_busy = tbl[r].busy;
        step();
        chk($sformatf("t1[%0d.%0d] send", r, k), serial_send, tbl[r].e_send);
        chk($sformatf("t1[%0d.%0d] pend", r, k), pending, tbl[r].e_pend);
        chk($sformatf("t1[%0d.%0d] act", r, k), tx_active, tbl[r].e_act);
        chk($sformatf("t1[%0d.%0d] gold", r, k), golden_nonce, tbl[r].e_gold);
        chk($sformatf("t1[%0d.%0d] ovf", r, k), overflow_count, 0);
      end

    // Round-robin order, then restart after slave 1
    do_reset();
    auto_core = 1'b1;
    new_nonces = 4'b1111; slave_nonces = pack(32'h10, 32'h11, 32'h12, 32'h13);
    step(); new_nonces = '0;
    wait_sent("rr count1", 4, 200);
    for (int i = 0; i < 4 && i < sent_q.size(); i++) chk($sformatf("rr1 word%0d", i), sent_q[i], 32'h10 + i);
    wait_quiet("rr quiet1", 50);
    sent_q.delete();
    new_nonces = 4'b0010; slave_nonces = pack(0, 32'h21, 0, 0);
    step(); new_nonces = '0;
    wait_sent("rr count2", 1, 50);
    wait_quiet("rr quiet2", 50);
    sent_q.delete();
    new_nonces = 4'b1111; slave_nonces = pack(32'h30, 32'h31, 32'h32, 32'h33);
    step(); new_nonces = '0;
    wait_sent("rr count3", 4, 200);
    for (int i = 0; i < 4 && i < sent_q.size(); i++) chk($sformatf("rr3 word%0d", i), sent_q[i], 32'h30 + ((i + 2) % 4));
    wait_quiet("rr quiet3", 50);

    // Overflow while busy, then saturation
    do_reset();
    man_busy = 1'b1;
    new_nonces = 4'b0100; slave_nonces = pack(0, 0, 32'hA, 0); step();
    new_nonces = '0; step();
    new_nonces = 4'b0100; slave_nonces = pack(0, 0, 32'hB, 0); step();
    new_nonces = '0; step();
    chk("ovf one drop", overflow_count, 1);
    chk("ovf pending", pending, 4'b0100);
    man_busy = 1'b0; step();
    chk("ovf send", serial_send, 1);
    chk("ovf word kept", golden_nonce, 32'hA);
    man_busy = 1'b1; repeat (3) step();
    man_busy = 1'b0; step();
    man_busy = 1'b1;
    new_nonces = 4'b0100; slave_nonces = pack(0, 0, 32'hC, 0); step();
    slave_nonces = pack(0, 0, 32'hD, 0);
    repeat (300) step();
    new_nonces = '0;
    chk("ovf saturate", overflow_count, 255);
    man_busy = 1'b0;
    wait_send("sat send", 10);
    chk("sat word", golden_nonce, 32'hC);
    man_busy = 1'b1; repeat (3) step();
    man_busy = 1'b0; step();

    // Same-cycle grant and capture on slave 1
    do_reset();
    man_busy = 1'b1;
    new_nonces = 4'b0010; slave_nonces = pack(0, 32'h55, 0, 0); step();
    new_nonces = '0; step();
    man_busy = 1'b0; new_nonces = 4'b0010; slave_nonces = pack(0, 32'h66, 0, 0); step();
    new_nonces = '0;
    chk("gc send", serial_send, 1);
    chk("gc old word", golden_nonce, 32'h55);
    chk("gc pending", pending, 4'b0010);
    chk("gc ovf", overflow_count, 0);
    man_busy = 1'b1; repeat (3) step();
    man_busy = 1'b0;
    wait_send("gc second", 10);
    chk("gc new word", golden_nonce, 32'h66);
    chk("gc ovf end", overflow_count, 0);
    man_busy = 1'b1; repeat (3) step();
    man_busy = 1'b0; repeat (2) step();

    // Busy never rises: timeout back to IDLE, next slot granted
    do_reset();
    new_nonces = 4'b1001; slave_nonces = pack(32'h70, 0, 0, 32'h73); step();
    new_nonces = '0; step();
    chk("to send", serial_send, 1);
    chk("to word0", golden_nonce, 32'h70);
    repeat (15) step();
    chk("to still active", tx_active, 1);
    chk("to ovf before", overflow_count, 0);
    step();
    chk("to idle", tx_active, 0);
    chk("to ovf", overflow_count, 1);
    step();
    chk("to next send", serial_send, 1);
    chk("to word3", golden_nonce, 32'h73);
    wait_quiet("to quiet", 40);

    // Reset during WAIT_DONE with three slots pending
    do_reset();
    new_nonces = 4'b1111; slave_nonces = pack(32'h80, 32'h81, 32'h82, 32'h83); step();
    new_nonces = '0; step();
    chk("rm send", serial_send, 1);
    man_busy = 1'b1; repeat (3) step();
    chk("rm pending", pending, 4'b1110);
    chk("rm active", tx_active, 1);
    do_reset();
    nsend = 0;
    for (int i = 0; i < 20; i++) begin step(); if (serial_send === 1'b1) nsend++; end
    chk("rm no send", nsend, 0);
    new_nonces = 4'b0100; slave_nonces = pack(0, 0, 32'h99, 0); step();
    new_nonces = '0;
    wait_send("rm resume", 10);
    chk("rm word", golden_nonce, 32'h99);
    wait_quiet("rm quiet", 40);

    // Randomized traffic against the model
    do_reset();
    auto_core = 1'b1; rise_lo = 1; rise_hi = 20; hold_lo = 1; hold_hi = 10;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < S; i++) begin
        rn[i] = ($urandom_range(4, 0) == 0);
        rv[i*NW +: NW] = $urandom;
      end
      new_nonces = rn; slave_nonces = rv;
      step();
    end
    new_nonces = '0;
    wait_quiet("rand quiet", 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
